// File: rtl/cu_pkg.sv
// Shared types and constants for the small-ALU control unit.
package cu_pkg;

  // Sequencer states; exported on the debug port as well.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FIN     = 3'd5,
    ST_ERR     = 3'd6
  } cu_state_e;

  // Functional unit addressed by an opcode.
  typedef enum logic [1:0] {
    UNIT_CALC = 2'd0,
    UNIT_DIV  = 2'd1,
    UNIT_MULT = 2'd2
  } cu_unit_e;

  // Opcodes 0-3 go to the calculator, 6-7 are illegal.
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MULT = 3'd5;

  // out_l source select.
  localparam logic [1:0] SEL_L_CALC = 2'b00;
  localparam logic [1:0] SEL_L_DIV  = 2'b01;
  localparam logic [1:0] SEL_L_MULT = 2'b10;

  // out_h source select.
  localparam logic SEL_H_DIV  = 1'b0;
  localparam logic SEL_H_MULT = 1'b1;

  // True for opcodes that address a real unit.
  function automatic logic op_is_legal(logic [2:0] op);
    return (op <= OP_MULT);
  endfunction

  // Map a legal opcode to its functional unit.
  function automatic cu_unit_e op_unit(logic [2:0] op);
    if (op == OP_DIV) begin
      return UNIT_DIV;
    end else if (op == OP_MULT) begin
      return UNIT_MULT;
    end
    return UNIT_CALC;
  endfunction

endpackage

// File: rtl/cu_dp_if.sv
// Control-unit <-> datapath handshake bundle.
// Handshake: the control unit is the initiator. go_calc/go_div are one-cycle
// launch pulses and go_mult is a level held until the multiplier reports done;
// a unit answers by raising its done_* flag (level or pulse), and only the
// first cycle the launched unit's flag is high while the control unit waits
// is taken as completion.
interface cu_dp_if;
  logic       en_x;
  logic       en_y;
  logic       go_calc;
  logic       go_div;
  logic       go_mult;
  logic [1:0] op_calc;
  logic [1:0] sel_l;
  logic       sel_h;
  logic       en_out_l;
  logic       en_out_h;
  logic       done_calc;
  logic       done_div;
  logic       done_mult;

  // Control unit side.
  modport master (
    output en_x, en_y, go_calc, go_div, go_mult, op_calc,
           sel_l, sel_h, en_out_l, en_out_h,
    input  done_calc, done_div, done_mult
  );

  // Datapath side.
  modport slave (
    input  en_x, en_y, go_calc, go_div, go_mult, op_calc,
           sel_l, sel_h, en_out_l, en_out_h,
    output done_calc, done_div, done_mult
  );
endinterface

// File: rtl/cu_watchdog.sv
// 8-bit clear/increment counter that flags when it reaches TIMEOUT.
module cu_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [7:0] count_d;
  logic [7:0] count_q;

  // Next count: clear wins, increment saturates so it never wraps to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TIMEOUT_C);

endmodule

// File: rtl/top_cu.sv
// Control unit sequencing the small-ALU datapath: load operands, launch the
// selected unit, wait for its done flag (with watchdog), capture the result.
// Every output is a flop loaded from a decode of the next state, so outputs
// line up with the state they belong to and never depend on inputs directly.
module top_cu
  import cu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] op,
  cu_dp_if.master    dp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output cu_state_e  dbg_state
);

  cu_state_e  state_d, state_q;
  logic [2:0] op_d, op_q;
  cu_unit_e   unit_d, unit_q;

  logic       en_x_d, en_x_q;
  logic       en_y_d, en_y_q;
  logic       go_calc_d, go_calc_q;
  logic       go_div_d, go_div_q;
  logic       go_mult_d, go_mult_q;
  logic [1:0] op_calc_d, op_calc_q;
  logic [1:0] sel_l_d, sel_l_q;
  logic       sel_h_d, sel_h_q;
  logic       en_out_l_d, en_out_l_q;
  logic       en_out_h_d, en_out_h_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic       err_d, err_q;

  logic       unit_done;
  logic       wd_expired;

  // Watchdog runs only while waiting; it sits cleared in every other state.
  cu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_WAIT),
    .inc     (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  // Done flag of the unit launched by the latched opcode; others are ignored.
  always_comb begin
    unit_q    = op_unit(op_q);
    unit_done = 1'b0;
    unique case (unit_q)
      UNIT_CALC: unit_done = dp.done_calc;
      UNIT_DIV:  unit_done = dp.done_div;
      UNIT_MULT: unit_done = dp.done_mult;
      default:   unit_done = 1'b0;
    endcase
  end

  // Next-state and opcode latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (op_is_legal(op)) begin
            op_d    = op;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving in the terminal-count cycle still completes.
        if (unit_done) begin
          state_d = ST_CAPTURE;
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_CAPTURE: state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state, registered below.
  always_comb begin
    unit_d     = op_unit(op_d);
    en_x_d     = (state_d == ST_LOAD);
    en_y_d     = (state_d == ST_LOAD);
    go_calc_d  = (state_d == ST_START) && (unit_d == UNIT_CALC);
    go_div_d   = (state_d == ST_START) && (unit_d == UNIT_DIV);
    go_mult_d  = ((state_d == ST_START) || (state_d == ST_WAIT)) &&
                 (unit_d == UNIT_MULT);
    op_calc_d  = 2'b00;
    if ((state_d == ST_LOAD) || (state_d == ST_START) ||
        (state_d == ST_WAIT) || (state_d == ST_CAPTURE)) begin
      op_calc_d = op_d[1:0];
    end
    sel_l_d    = SEL_L_CALC;
    sel_h_d    = SEL_H_DIV;
    en_out_l_d = 1'b0;
    en_out_h_d = 1'b0;
    if (state_d == ST_CAPTURE) begin
      unique case (unit_d)
        UNIT_CALC: begin
          // out_h keeps its previous value for calculator results.
          sel_l_d    = SEL_L_CALC;
          en_out_l_d = 1'b1;
        end
        UNIT_DIV: begin
          sel_l_d    = SEL_L_DIV;
          sel_h_d    = SEL_H_DIV;
          en_out_l_d = 1'b1;
          en_out_h_d = 1'b1;
        end
        UNIT_MULT: begin
          sel_l_d    = SEL_L_MULT;
          sel_h_d    = SEL_H_MULT;
          en_out_l_d = 1'b1;
          en_out_h_d = 1'b1;
        end
        default: begin
          sel_l_d = SEL_L_CALC;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    err_d  = (state_d == ST_ERR);
  end

  // Sequencer state, latched opcode and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      en_x_q     <= 1'b0;
      en_y_q     <= 1'b0;
      go_calc_q  <= 1'b0;
      go_div_q   <= 1'b0;
      go_mult_q  <= 1'b0;
      op_calc_q  <= 2'b00;
      sel_l_q    <= 2'b00;
      sel_h_q    <= 1'b0;
      en_out_l_q <= 1'b0;
      en_out_h_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      en_x_q     <= en_x_d;
      en_y_q     <= en_y_d;
      go_calc_q  <= go_calc_d;
      go_div_q   <= go_div_d;
      go_mult_q  <= go_mult_d;
      op_calc_q  <= op_calc_d;
      sel_l_q    <= sel_l_d;
      sel_h_q    <= sel_h_d;
      en_out_l_q <= en_out_l_d;
      en_out_h_q <= en_out_h_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dp.en_x     = en_x_q;
  assign dp.en_y     = en_y_q;
  assign dp.go_calc  = go_calc_q;
  assign dp.go_div   = go_div_q;
  assign dp.go_mult  = go_mult_q;
  assign dp.op_calc  = op_calc_q;
  assign dp.sel_l    = sel_l_q;
  assign dp.sel_h    = sel_h_q;
  assign dp.en_out_l = en_out_l_q;
  assign dp.en_out_h = en_out_h_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_top_cu.sv
// Bench for top_cu: two instances (TIMEOUT=255 and TIMEOUT=4) see the same
// command stream; a cycle-trace model derived from the timing rules predicts
// every output of each instance on every cycle.
module tb_top_cu;
  import cu_pkg::*;

  localparam int W     = 15;
  localparam int TMO_A = 255;
  localparam int TMO_B = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go  = 1'b0;
  logic [2:0] op  = 3'd0;
  logic       d_calc = 1'b0, d_div = 1'b0, d_mult = 1'b0;

  always #5 clk = ~clk;

  logic      busy_a, done_a, err_a, busy_b, done_b, err_b;
  cu_state_e st_a, st_b;

  cu_dp_if dp_a ();
  cu_dp_if dp_b ();

  assign dp_a.done_calc = d_calc;
  assign dp_a.done_div  = d_div;
  assign dp_a.done_mult = d_mult;
  assign dp_b.done_calc = d_calc;
  assign dp_b.done_div  = d_div;
  assign dp_b.done_mult = d_mult;

  top_cu #(.TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .go(go), .op(op), .dp(dp_a),
    .busy(busy_a), .done(done_a), .err(err_a), .dbg_state(st_a)
  );

  top_cu #(.TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .go(go), .op(op), .dp(dp_b),
    .busy(busy_b), .done(done_b), .err(err_b), .dbg_state(st_b)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  // Output vector: busy done err en_x en_y go_calc go_div go_mult
  //                op_calc[2] sel_l[2] sel_h en_out_l en_out_h
  function automatic logic [W-1:0] sample_a();
    return {busy_a, done_a, err_a, dp_a.en_x, dp_a.en_y, dp_a.go_calc,
            dp_a.go_div, dp_a.go_mult, dp_a.op_calc, dp_a.sel_l,
            dp_a.sel_h, dp_a.en_out_l, dp_a.en_out_h};
  endfunction

  function automatic logic [W-1:0] sample_b();
    return {busy_b, done_b, err_b, dp_b.en_x, dp_b.en_y, dp_b.go_calc,
            dp_b.go_div, dp_b.go_mult, dp_b.op_calc, dp_b.sel_l,
            dp_b.sel_h, dp_b.en_out_l, dp_b.en_out_h};
  endfunction

  function automatic logic [W-1:0] vec(bit b, bit dn, bit er, bit exy,
                                       bit gc, bit gd, bit gm,
                                       logic [1:0] opc, logic [1:0] sl,
                                       bit sh, bit eol, bit eoh);
    return {b, dn, er, exy, exy, gc, gd, gm, opc, sl, sh, eol, eoh};
  endfunction

  // ---------------- reference model ----------------
  // Trace of outputs for the cycles after go is sampled, ending with one idle
  // cycle. dly = WAIT cycle in which the unit's done first shows (-1: never).
  task automatic build_trace(input logic [2:0] o, input int dly, input int tmo);
    bit         calc, dv, ml, ok;
    logic [1:0] oc, sl;
    int         nwait;
    exp_q.delete();
    calc = (o < 3'd4);
    dv   = (o == 3'd4);
    ml   = (o == 3'd5);
    oc   = o[1:0];
    if (o > 3'd5) begin
      exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
      exp_q.push_back('0);
      return;
    end
    exp_q.push_back(vec(1, 0, 0, 1, 0, 0, 0, oc, 2'd0, 0, 0, 0));
    exp_q.push_back(vec(1, 0, 0, 0, calc, dv, ml, oc, 2'd0, 0, 0, 0));
    ok    = (dly >= 0) && (dly <= tmo);
    nwait = ok ? dly + 1 : tmo + 1;
    for (int i = 0; i < nwait; i++)
      exp_q.push_back(vec(1, 0, 0, 0, 0, 0, ml, oc, 2'd0, 0, 0, 0));
    if (ok) begin
      sl = calc ? 2'd0 : (dv ? 2'd1 : 2'd2);
      exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, oc, sl, ml, 1, !calc));
      exp_q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
    end else begin
      exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));
    end
    exp_q.push_back('0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with both instances idle; returns at the negedge of
  // the last traced cycle. level: done held high once raised; stale: extra
  // done pulse on the launched unit before WAIT; noise: random go during
  // busy and random done on the other units; rst_at: cycle to pulse reset.
  task automatic drive_cmd(input logic [2:0] o, input int dly, input bit level,
                           input bit stale, input bit noise, input int rst_at);
    int  n;
    bit  sel;
    build_trace(o, dly, TMO_A); exp_a = exp_q;
    build_trace(o, dly, TMO_B); exp_b = exp_q;
    if (rst_at >= 0) begin
      while (exp_a.size() > rst_at + 1) void'(exp_a.pop_back());
      while (exp_b.size() > rst_at + 1) void'(exp_b.pop_back());
      exp_a.push_back('0);
      exp_b.push_back('0);
    end
    n = (exp_a.size() > exp_b.size()) ? exp_a.size() : exp_b.size();
    while (exp_a.size() < n) exp_a.push_back('0);
    while (exp_b.size() < n) exp_b.push_back('0);
    obs_a.delete();
    obs_b.delete();
    go = 1'b1;
    op = o;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      go = 1'b0;
      if (noise && exp_a[c][W-1] && exp_b[c][W-1]) begin
        go = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
      end
      sel = ((dly >= 0) && (level ? (c >= 2 + dly) : (c == 2 + dly))) ||
            (stale && (c < 2));
      d_calc = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      d_div  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      d_mult = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (o < 3'd4)       d_calc = sel;
      else if (o == 3'd4) d_div  = sel;
      else if (o == 3'd5) d_mult = sel;
      rst = (rst_at >= 0) && (c == rst_at);
      @(negedge clk);
      obs_a.push_back(sample_a());
      obs_b.push_back(sample_b());
      if (c < n - 1) begin
        @(posedge clk); #1;
      end
    end
    go = 1'b0; rst = 1'b0;
    d_calc = 1'b0; d_div = 1'b0; d_mult = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) begin
      @(posedge clk); #1;
      go = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    total++;
    if (sample_a() !== '0 || st_a !== ST_IDLE) begin
      bad++; $display("FAIL reset_a: got %h/%0d want 0/IDLE", sample_a(), st_a);
    end
    total++;
    if (sample_b() !== '0 || st_b !== ST_IDLE) begin
      bad++; $display("FAIL reset_b: got %h/%0d want 0/IDLE", sample_b(), st_b);
    end
    rst = 1'b0; go = 1'b0;
    @(negedge clk);
    total++;
    if (sample_a() !== '0) begin
      bad++; $display("FAIL reset_release: got %h want 0", sample_a());
    end
  endtask

  task automatic test_calc();
    drive_cmd(3'd1, 1, 0, 0, 0, -1);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL calc_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL calc_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_div();
    // done_div at t+8 = WAIT cycle 5: A completes, B (TIMEOUT=4) times out.
    drive_cmd(3'd4, 5, 0, 1, 0, -1);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL div_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL div_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_mult();
    drive_cmd(3'd5, 3, 1, 0, 1, -1);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL mult_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL mult_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_illegal();
    for (int k = 6; k <= 7; k++) begin
      drive_cmd(3'(k), 0, 0, 0, 1, -1);
      for (int c = 0; c < exp_a.size(); c++) begin
        total += 2;
        if (obs_a[c] !== exp_a[c]) begin
          bad++; $display("FAIL illegal%0d_a cyc %0d: got %h want %h", k, c, obs_a[c], exp_a[c]);
        end
        if (obs_b[c] !== exp_b[c]) begin
          bad++; $display("FAIL illegal%0d_b cyc %0d: got %h want %h", k, c, obs_b[c], exp_b[c]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    // No done ever: both instances run into their watchdogs.
    drive_cmd(3'd4, -1, 0, 0, 1, -1);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL timeout_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL timeout_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cmd(3'd5, -1, 0, 0, 0, 4);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL rstmid_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL rstmid_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
    drive_cmd(3'd0, 2, 0, 0, 1, -1);
    for (int c = 0; c < exp_a.size(); c++) begin
      total += 2;
      if (obs_a[c] !== exp_a[c]) begin
        bad++; $display("FAIL after_rst_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
      end
      if (obs_b[c] !== exp_b[c]) begin
        bad++; $display("FAIL after_rst_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Each command is issued in the first idle cycle after the previous one.
    for (int k = 0; k < 40; k++) begin
      logic [2:0] o;
      int         dly;
      o   = 3'($urandom_range(0, 7));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7));
      drive_cmd(o, dly, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b1, -1);
      for (int c = 0; c < exp_a.size(); c++) begin
        total += 2;
        if (obs_a[c] !== exp_a[c]) begin
          bad++; $display("FAIL rand%0d_a op %0d dly %0d cyc %0d: got %h want %h",
                          k, o, dly, c, obs_a[c], exp_a[c]);
        end
        if (obs_b[c] !== exp_b[c]) begin
          bad++; $display("FAIL rand%0d_b op %0d dly %0d cyc %0d: got %h want %h",
                          k, o, dly, c, obs_b[c], exp_b[c]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_calc();
    test_div();
    test_mult();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound in case the sequence stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: sequence still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/top_cu.md
# top_cu

Control unit for the small-ALU datapath (x/y operand registers, 4-bit calculator, divider, pipelined multiplier, out_h/out_l result registers). It accepts a user command (go + opcode) and sequences the datapath: loads operands, launches the selected functional unit, waits for its done flag, steers and captures the result, then signals completion. It is the initiator on the datapath's go/done handshake. A watchdog aborts any operation whose done never arrives.

## Interface
Parameters:
- TIMEOUT, 255: max cycles spent in WAIT before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start command; sampled only in IDLE
- op  in  3  command opcode: 0-3 calculator (op_calc = op[1:0]), 4 divide, 5 multiply, 6-7 illegal
- done_calc, done_div, done_mult  in  1 each  completion flags from datapath units
- en_x, en_y  out  1  operand register load enables
- go_calc, go_div  out  1  single-cycle launch pulses
- go_mult  out  1  multiplier pipeline enable (level, see Operation)
- op_calc  out  2  calculator function select
- sel_l  out  2  out_l source: 00 calc, 01 div quotient, 10 mult low, 11 unused
- sel_h  out  1  out_h source: 0 div remainder, 1 mult high
- en_out_l, en_out_h  out  1  result register load enables
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on illegal opcode or timeout

## Operation
- States: IDLE, LOAD, START, WAIT, CAPTURE, FIN, ERR.
- IDLE: go=1 with op 0-5 → latch op, go to LOAD. go=1 with op 6/7 → ERR (no enables asserted). go=0 → stay.
- LOAD: en_x=en_y=1 for one cycle → START.
- START: calc: go_calc=1 one cycle; div: go_div=1 one cycle; mult: go_mult rises. → WAIT, watchdog cleared to 0.
- WAIT: go_mult held high for mult ops until done seen. Watches only the done flag of the latched unit; others ignored. Done=1 → CAPTURE. Otherwise watchdog increments; watchdog reaching TIMEOUT → ERR.
- CAPTURE (one cycle): calc: sel_l=00, en_out_l=1, en_out_h=0 (out_h holds). div: sel_l=01, sel_h=0, both enables. mult: sel_l=10, sel_h=1, both enables. go_mult drops here. → FIN.
- FIN: done=1 → IDLE.
- ERR: err=1 → IDLE.
- op_calc driven from latched op[1:0] from LOAD through CAPTURE; 00 otherwise.
- go in any non-IDLE state ignored; new command accepted only after returning to IDLE.
- Done flags accepted as level or pulse: first cycle high in WAIT counts; a done asserted before WAIT (stale) is ignored.

## Timing
- Reset: state IDLE, latched op 0, watchdog 0; every output 0 (en_*, go_*, op_calc, sel_l, sel_h, busy, done, err).
- Reset mid-operation: same values next cycle; go_mult drops immediately; no done/err pulse.
- go seen at edge t → LOAD t+1, START t+2, WAIT from t+3.
- Done flag high in cycle w of WAIT → CAPTURE w+1, done pulse w+2, IDLE w+3; earliest done pulse at t+5 (done at t+3).
- Illegal op at t → err at t+1, IDLE at t+2.
- Timeout: err pulse TIMEOUT+1 cycles after entering WAIT; datapath result registers untouched.
- All outputs registered or pure functions of state; no combinational path from inputs to outputs.

## Structure
- Package cu_pkg: state enum, opcode constants (OP_DIV=4, OP_MULT=5), sel_l/sel_h encodings.
- One sub-module: cu_watchdog (8-bit clear/increment counter with terminal-count flag compared to TIMEOUT).

## Test plan
- Reset then op=1, go: en_x/en_y at t+1, go_calc at t+2, op_calc=01; done_calc at t+4 → en_out_l=1, sel_l=00, en_out_h=0 at t+5, done at t+6.
- op=4, done_div at t+8 → CAPTURE sel_l=01, sel_h=0, both enables; done t+10; go_div only one cycle wide.
- op=5: go_mult high t+2 through done_mult cycle, low in CAPTURE; sel_l=10, sel_h=1.
- op=6 → err pulse t+1, no en_*/go_* asserted; op=7 same.
- TIMEOUT=4, op=4, done_div never asserted → err 5 cycles after WAIT entry, no en_out_*, busy drops next cycle.
- rst asserted in WAIT of a mult op → all outputs 0 next cycle; go_mult low; subsequent op=0 command completes normally; go pulsed during busy ignored.
